// File: rtl/rom_slave_pkg.sv
// Shared constants, response type and boot image generator for the ROM slave.
package rom_slave_pkg;

    localparam logic [31:0] ROM_BASE_ADDR   = 32'h0000_0000;
    localparam int          ROM_BITS        = 10;
    localparam logic [31:0] ROM_END_ADDR    = ROM_BASE_ADDR + (32'd4 << ROM_BITS) - 32'd1;
    localparam int          ROM_MAX_LATENCY = 4;

    typedef struct packed {
        logic        err;
        logic [31:0] data;
    } rom_rsp_t;

    // Default boot image: a recognisable tag XORed with the word index, plus a marker at word 2.
    function automatic logic [31:0] rom_image_word(input logic [31:0] idx);
        return (idx == 32'd2) ? 32'hDEAD_BEEF : (32'hC0DE_0000 ^ idx);
    endfunction

endpackage

// File: rtl/rom_sync_array.sv
// Synchronous-read ROM array; contents come from the package boot image generator.
module rom_sync_array
    import rom_slave_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024,
    parameter int AW     = 10
) (
    input  logic              clk,
    input  logic              en,
    input  logic [AW-1:0]     addr,
    output logic [DATA_W-1:0] q
);

    always_ff @(posedge clk) begin
        if (en) q <= DATA_W'(rom_image_word(32'(addr)));
    end

endmodule

// File: rtl/rom_slave.sv
// Pipelined ROM slave with valid/ready channels, credit flow control and in-order response FIFO.
// Optional perf counters are built when ROM_PERF_CNT_EN is defined.
module rom_slave
    import rom_slave_pkg::*;
#(
    parameter int          DATA_W    = 32,
    parameter int          ROM_WORDS = 1 << ROM_BITS,
    parameter logic [31:0] BASE_ADDR = ROM_BASE_ADDR,
    parameter int          LATENCY   = 2,
    parameter int          ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
`ifdef ROM_PERF_CNT_EN
    input  logic              perf_clr,
    output logic [31:0]       perf_acc,
    output logic [31:0]       perf_err,
`endif
    output logic              rsp_err
);

    localparam int                CREDITS   = LATENCY + 1;
    localparam int                BW        = $clog2(DATA_W / 8);
    localparam int                AW        = (ROM_WORDS > 1) ? $clog2(ROM_WORDS) : 1;
    localparam int                PW        = $clog2(CREDITS);
    localparam int                CW        = $clog2(CREDITS + 1);
    localparam logic [ADDR_W:0]   ROM_BYTES = (ADDR_W + 1)'(ROM_WORDS * (DATA_W / 8));
    localparam logic [ADDR_W-1:0] LANE_MASK = ADDR_W'(DATA_W / 8 - 1);

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(CREDITS - 1)) ? '0 : p + 1'b1;
    endfunction

    logic              accept, pop, fifo_pop, push;
    logic [ADDR_W-1:0] off;
    logic              dec_err;
    logic [AW-1:0]     dec_idx;
    logic [DATA_W-1:0] q;
    logic [LATENCY:1]  vld_p;
    logic [LATENCY:1]  err_p;
    logic [DATA_W-1:0] stage_dat, stage_word;
    logic              stage_vld, stage_err;
    logic [DATA_W-1:0] fifo_dat [CREDITS];
    logic              fifo_err [CREDITS];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     fcnt, inflight, infl_nxt;
    logic              fifo_empty;

    assign accept = req_valid && req_ready;

    // Stage 0: decode at accept; the array read is clocked into stage 1
    always_comb begin
        off     = req_addr - ADDR_W'(BASE_ADDR);
        dec_err = ({1'b0, off} >= ROM_BYTES) || ((req_addr & LANE_MASK) != '0);
        dec_idx = AW'(off >> BW);
    end

    rom_sync_array #(
        .DATA_W(DATA_W),
        .DEPTH (ROM_WORDS),
        .AW    (AW)
    ) u_array (
        .clk (clk),
        .en  (accept),
        .addr(dec_idx),
        .q   (q)
    );

    // Stages 1..LATENCY: valid and error flags shift alongside the read word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p <= '0;
        end else begin
            vld_p[1] <= accept;
            for (int j = 2; j <= LATENCY; j++) vld_p[j] <= vld_p[j-1];
        end
    end

    always_ff @(posedge clk) begin
        err_p[1] <= dec_err;
        for (int j = 2; j <= LATENCY; j++) err_p[j] <= err_p[j-1];
    end

    generate
        if (LATENCY == 1) begin : g_lat1
            assign stage_dat = q;
        end else begin : g_latn
            logic [DATA_W-1:0] dat_p [LATENCY-1];
            always_ff @(posedge clk) begin
                dat_p[0] <= q;
                for (int k = 1; k < LATENCY - 1; k++) dat_p[k] <= dat_p[k-1];
            end
            assign stage_dat = dat_p[LATENCY-2];
        end
    endgenerate

    assign stage_vld  = vld_p[LATENCY];
    assign stage_err  = err_p[LATENCY];
    assign stage_word = stage_err ? '0 : stage_dat;

    // Response FIFO: the final stage falls through when the queue is empty, so a
    // response appears LATENCY cycles after its accept cycle and is popped in place.
    assign fifo_empty = (fcnt == '0);
    assign rsp_valid  = !fifo_empty || stage_vld;
    assign pop        = rsp_valid && rsp_ready;
    assign fifo_pop   = pop && !fifo_empty;
    assign push       = stage_vld && !(fifo_empty && pop);

    always_comb begin
        rsp_data = '0;
        rsp_err  = 1'b0;
        if (!fifo_empty) begin
            rsp_data = fifo_dat[rd_ptr];
            rsp_err  = fifo_err[rd_ptr];
        end else if (stage_vld) begin
            rsp_data = stage_word;
            rsp_err  = stage_err;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_dat[wr_ptr] <= stage_word;
            fifo_err[wr_ptr] <= stage_err;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fcnt   <= '0;
        end else begin
            if (push)     wr_ptr <= ptr_inc(wr_ptr);
            if (fifo_pop) rd_ptr <= ptr_inc(rd_ptr);
            case ({push, fifo_pop})
                2'b10:   fcnt <= fcnt + 1'b1;
                2'b01:   fcnt <= fcnt - 1'b1;
                default: fcnt <= fcnt;
            endcase
        end
    end

    // Credits: req_ready is a register fed only by the updated in-flight count
    always_comb begin
        infl_nxt = inflight;
        if (accept && !pop)      infl_nxt = inflight + 1'b1;
        else if (!accept && pop) infl_nxt = inflight - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight  <= '0;
            req_ready <= 1'b0;
        end else begin
            inflight  <= infl_nxt;
            req_ready <= (infl_nxt < CW'(CREDITS));
        end
    end

    fifo_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !fifo_pop && (fcnt == CW'(CREDITS))));

`ifdef ROM_PERF_CNT_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic inc);
        return (inc && (v != '1)) ? v + 32'd1 : v;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_acc <= '0;
            perf_err <= '0;
        end else if (perf_clr) begin
            perf_acc <= '0;
            perf_err <= '0;
        end else begin
            perf_acc <= sat_inc(perf_acc, accept);
            perf_err <= sat_inc(perf_err, accept && dec_err);
        end
    end
`endif

endmodule
